// File: rtl/keystream_xor.sv
// ---------------------------------------------------------------------------
// keystream_xor
//
// Buffers one keystream block from the block-function/serialiser stage and
// XORs it, element by element, into a byte stream. The result goes to the
// MAC input stage. When a block has been captured, ks_ack tells upstream it
// may start generating the next one.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   ks_block     keystream block, element 0 is consumed first
//   ks_valid     upstream block present and stable
//   ks_ack       one-cycle pulse after a block has been captured
//   pt_data      input byte
//   pt_valid     input byte valid
//   pt_last      input byte is the final byte of the message
//   pt_ready     input byte accepted this cycle
//   ct_data      output byte (pt_data ^ keystream element)
//   ct_valid     output byte valid
//   ct_last      output byte is the final byte of the message
//   ct_ready     downstream accepts output byte
//   blocks_used  number of keystream blocks captured since reset
// ---------------------------------------------------------------------------
module keystream_xor #(
    parameter int DATA_SIZE = 8,
    parameter int NO_REG    = 64,
    parameter int CNT_W     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NO_REG-1:0][DATA_SIZE-1:0]   ks_block,
    input  logic                               ks_valid,
    output logic                               ks_ack,
    input  logic [DATA_SIZE-1:0]               pt_data,
    input  logic                               pt_valid,
    input  logic                               pt_last,
    output logic                               pt_ready,
    output logic [DATA_SIZE-1:0]               ct_data,
    output logic                               ct_valid,
    output logic                               ct_last,
    input  logic                               ct_ready,
    output logic [CNT_W-1:0]                   blocks_used
);

    localparam int              IDX_W    = (NO_REG > 1) ? $clog2(NO_REG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REG - 1);

    typedef enum logic {
        S_EMPTY,
        S_STREAM
    } state_t;

    state_t                             r_state;
    logic [IDX_W-1:0]                   r_idx;
    logic [NO_REG-1:0][DATA_SIZE-1:0]   r_ks_buf;
    logic                               r_ks_ack;
    logic [DATA_SIZE-1:0]               r_ct_data;
    logic                               r_ct_valid;
    logic                               r_ct_last;
    logic [CNT_W-1:0]                   r_blocks_used;

    logic                               w_pt_ready;
    logic                               w_fire;
    logic                               w_blk_end;
    logic [DATA_SIZE-1:0]               w_ks_byte;

    // A new byte is taken only when the output register is free or being
    // drained in the same cycle, so backpressure never drops a byte.
    assign w_pt_ready = (r_state == S_STREAM) && (!r_ct_valid || ct_ready);
    assign w_fire     = pt_valid && w_pt_ready;
    assign w_ks_byte  = r_ks_buf[r_idx];

    // Message end and block exhaustion share one exit to S_EMPTY. The rest
    // of a block cut short by pt_last is discarded and never reused.
    assign w_blk_end  = w_fire && (pt_last || (r_idx == IDX_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_EMPTY;
            r_idx         <= '0;
            r_ks_buf      <= '0;
            r_ks_ack      <= 1'b0;
            r_ct_data     <= '0;
            r_ct_valid    <= 1'b0;
            r_ct_last     <= 1'b0;
            r_blocks_used <= '0;
        end else begin
            r_ks_ack <= 1'b0;

            case (r_state)
                S_EMPTY: begin
                    // ks_block is sampled only here; it is ignored at any
                    // other time.
                    if (ks_valid) begin
                        r_ks_buf      <= ks_block;
                        r_idx         <= '0;
                        r_ks_ack      <= 1'b1;
                        r_blocks_used <= r_blocks_used + 1'b1;
                        r_state       <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_fire) begin
                        if (w_blk_end) begin
                            r_idx   <= '0;
                            r_state <= S_EMPTY;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
            endcase

            // The output register is independent of the FSM. A byte that is
            // still pending after a block ends drains normally.
            if (w_fire) begin
                r_ct_data  <= pt_data ^ w_ks_byte;
                r_ct_last  <= pt_last;
                r_ct_valid <= 1'b1;
            end else if (ct_ready) begin
                r_ct_valid <= 1'b0;
            end
        end
    end

    assign pt_ready    = w_pt_ready;
    assign ks_ack      = r_ks_ack;
    assign ct_data     = r_ct_data;
    assign ct_valid    = r_ct_valid;
    assign ct_last     = r_ct_last;
    assign blocks_used = r_blocks_used;

endmodule

// File: tb/tb_keystream_xor.sv
// ---------------------------------------------------------------------------
// tb_keystream_xor
//
// Scoreboard bench for keystream_xor. The stimulus tasks push the expected
// {ct_last, ct_data} for every accepted input byte. A monitor pops an entry
// on each ct handshake and compares it with the DUT output.
// ---------------------------------------------------------------------------
module tb_keystream_xor;

    localparam int DS = 8;
    localparam int NR = 64;
    localparam int CW = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NR-1:0][DS-1:0]   ks_block;
    logic                    ks_valid;
    logic                    ks_ack;
    logic [DS-1:0]           pt_data;
    logic                    pt_valid;
    logic                    pt_last;
    logic                    pt_ready;
    logic [DS-1:0]           ct_data;
    logic                    ct_valid;
    logic                    ct_last;
    logic                    ct_ready;
    logic [CW-1:0]           blocks_used;

    always #5 clk = ~clk;

    keystream_xor #(
        .DATA_SIZE (DS),
        .NO_REG    (NR),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ks_block    (ks_block),
        .ks_valid    (ks_valid),
        .ks_ack      (ks_ack),
        .pt_data     (pt_data),
        .pt_valid    (pt_valid),
        .pt_last     (pt_last),
        .pt_ready    (pt_ready),
        .ct_data     (ct_data),
        .ct_valid    (ct_valid),
        .ct_last     (ct_last),
        .ct_ready    (ct_ready),
        .blocks_used (blocks_used)
    );

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          ack_cnt = 0;
    logic [8:0]  sb_q[$];
    logic [8:0]  sb_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever
    // ct_valid & ct_ready are seen high on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && ct_valid === 1'b1 && ct_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ct_unexpected: got last=%0b data=0x%0h, expected no output", ct_last, ct_data);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("ct_byte", 64'({ct_last, ct_data}), 64'(sb_exp));
            end
        end
        if (rst === 1'b1 && ks_ack === 1'b1) ack_cnt++;
    end

    task automatic scramble_ks();
        for (int i = 0; i < NR; i++) ks_block[i] = 8'($urandom());
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // edge on which the byte is accepted.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] k, input logic l);
        int t;
        t        = 0;
        pt_data  = d;
        pt_last  = l;
        pt_valid = 1'b1;
        @(negedge clk);
        while (pt_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (pt_ready !== 1'b1) begin
            chk("pt_ready_timeout", 64'(pt_ready), 64'd1);
            pt_valid = 1'b0;
            return;
        end
        sb_q.push_back({l, d ^ k});
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    task automatic supply(input logic [NR-1:0][DS-1:0] b);
        int t;
        t        = 0;
        ks_block = b;
        ks_valid = 1'b1;
        @(negedge clk);
        while (ks_ack !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("ks_ack_seen", 64'(ks_ack), 64'd1);
        @(posedge clk);
        #1;
        ks_valid = 1'b0;
        scramble_ks();
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        ct_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    logic [NR-1:0][DS-1:0] blk_a;
    logic [NR-1:0][DS-1:0] blk_b;
    logic [NR-1:0][DS-1:0] blk5 [3];
    int                    ack0;

    initial begin
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        pt_data  = '0;
        ct_ready = 1'b1;
        scramble_ks();

        // T1: reset with random inputs
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            scramble_ks();
            ks_valid = 1'($urandom());
            pt_valid = 1'($urandom());
            pt_last  = 1'($urandom());
            pt_data  = 8'($urandom());
            ct_ready = 1'($urandom());
            @(negedge clk);
            chk("rst_outputs", 64'({ct_valid, ct_last, ct_data, ks_ack, pt_ready}), 64'd0);
            chk("rst_blocks_used", 64'(blocks_used), 64'd0);
        end
        @(posedge clk);
        #1;
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        ct_ready = 1'b1;
        sb_q.delete();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_pt_ready", 64'({pt_ready, ks_ack}), 64'd0);
        end
        @(posedge clk);
        #1;

        // T2: one full block of 0xA5
        do_reset();
        for (int i = 0; i < NR; i++) blk_a[i] = 8'hA5;
        ack0 = ack_cnt;
        fork
            supply(blk_a);
            begin
                for (int i = 0; i < NR; i++) send_byte(8'(i), 8'hA5, 1'b0);
            end
        join
        chk("t2_pt_ready_after_63", 64'(pt_ready), 64'd0);
        drain();
        chk("t2_ack_count", 64'(ack_cnt - ack0), 64'd1);
        chk("t2_blocks_used", 64'(blocks_used), 64'd1);

        // T3: short message, then a fresh block for the next message
        do_reset();
        for (int i = 0; i < NR; i++) blk_a[i] = 8'(i);
        fork
            supply(blk_a);
            begin
                for (int i = 0; i <= 10; i++) send_byte(8'hFF, 8'(i), (i == 10));
            end
        join
        chk("t3_pt_ready_after_last", 64'(pt_ready), 64'd0);
        for (int i = 0; i < NR; i++) blk_b[i] = 8'h3C;
        blk_b[1] = 8'h99;
        fork
            supply(blk_b);
            send_byte(8'h00, 8'h3C, 1'b1);
        join
        drain();
        chk("t3_blocks_used", 64'(blocks_used), 64'd2);

        // T4: backpressure mid-block
        do_reset();
        for (int i = 0; i < NR; i++) blk_a[i] = 8'h5A;
        fork
            supply(blk_a);
            begin
                for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h20), 8'h5A, 1'b0);
                ct_ready = 1'b0;
                pt_data  = 8'h2A;
                pt_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("t4_pt_ready_stall", 64'(pt_ready), 64'd0);
                    // byte 9 = 0x29 ^ 0x5A = 0x73, held with valid=1 last=0
                    chk("t4_ct_hold", 64'({ct_valid, ct_last, ct_data}), 64'h273);
                    @(posedge clk);
                    #1;
                end
                ct_ready = 1'b1;
                for (int i = 10; i < 16; i++) send_byte(8'(i + 8'h20), 8'h5A, (i == 15));
            end
        join
        drain();

        // T5: 130-byte message over three blocks
        do_reset();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < NR; i++) blk5[b][i] = 8'((b * 64 + i) * 37 + 11);
        ack0 = ack_cnt;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    if (b > 0) begin
                        repeat (3) @(posedge clk);
                        #1;
                    end
                    supply(blk5[b]);
                end
            end
            begin
                for (int j = 0; j < 130; j++)
                    send_byte(8'(j * 5 + 3), blk5[j / 64][j % 64], (j == 129));
            end
        join
        drain();
        chk("t5_ack_count", 64'(ack_cnt - ack0), 64'd3);
        chk("t5_blocks_used", 64'(blocks_used), 64'd3);

        // T6: reset mid-stream at idx 20 with a pending output byte
        do_reset();
        for (int i = 0; i < NR; i++) blk_a[i] = 8'(i * 3);
        fork
            supply(blk_a);
            begin
                for (int i = 0; i < 20; i++) send_byte(8'(i), 8'(i * 3), 1'b0);
            end
        join
        ct_ready = 1'b0;
        #1;
        chk("t6_pending_before_rst", 64'(ct_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_async_clear", 64'({ct_valid, ct_last, ct_data, ks_ack, pt_ready}), 64'd0);
        chk("t6_blocks_used_clear", 64'(blocks_used), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        ct_ready = 1'b1;
        @(negedge clk);
        chk("t6_pt_ready_after_rel", 64'(pt_ready), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) blk_b[i] = 8'(i + 8'h10);
        fork
            supply(blk_b);
            send_byte(8'h00, 8'h10, 1'b1);
        join
        drain();
        chk("t6_blocks_used", 64'(blocks_used), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
